axi_slave_responder: RTL and testbench
======================================

# axi_slave_responder
Memory-backed AXI slave that answers an AXI master's single-beat reads and writes, the responder end of the axi_if master/slave channel set; it is used as a standalone target for verification and as the backing store for bring-up. Write and read paths are independent FSMs over a DEPTH-word register file with byte strobes and address-range checking, and each response echoes the request's 4-bit transaction ID.
## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- DEPTH, 16, number of DATA_WIDTH words (power of 2, ≥2)
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- awaddr  input  ADDR_WIDTH  write address
- awvalid  input  1  write address valid
- awready  output  1  write address ready
- aw_transaction_id  input  4  write request ID
- wdata  input  DATA_WIDTH  write data
- wstrb  input  DATA_WIDTH/8  byte enables
- wlast  input  1  last beat (must be 1)
- wvalid  input  1  write data valid
- wready  output  1  write data ready
- w_transaction_id  input  4  write data ID
- bresp  output  2  write response
- bvalid  output  1  write response valid
- bready  input  1  write response ready
- b_transaction_id  output  4  write response ID
- araddr  input  ADDR_WIDTH  read address
- arvalid  input  1  read address valid
- arready  output  1  read address ready
- ar_transaction_id  input  4  read request ID
- rdata  output  DATA_WIDTH  read data
- rresp  output  2  read response
- rlast  output  1  last beat (always 1 with rvalid)
- rvalid  output  1  read data valid
- rready  input  1  read data ready
- r_transaction_id  output  4  read response ID
## Operation
- Word index = addr >> log2(DATA_WIDTH/8); low byte bits ignored. In range iff addr < DEPTH*DATA_WIDTH/8, otherwise SLVERR (2'b10); OKAY = 2'b00.
- Write FSM W_IDLE/W_RESP. In W_IDLE, AW and W are accepted independently and each is latched (addr+ID / data+strb+last+ID); awready = W_IDLE & no AW held, wready = W_IDLE & no W held.
- On the edge where both AW and W are held or handshaking: commit, then W_RESP with bvalid=1 and b_transaction_id=AW ID. The commit writes only strobed bytes and sets bresp=OKAY. Out of range, wlast=0, or w_transaction_id≠aw_transaction_id: no write, bresp=SLVERR.
- W_RESP holds bvalid/bresp/ID stable until bvalid&bready, then W_IDLE with latches cleared.
- Read FSM R_IDLE/R_DATA; arready = R_IDLE. On arvalid&arready: capture mem[index] (or 0 if out of range), rresp, and ID; enter R_DATA with rvalid=rlast=1. Hold until rvalid&rready, then R_IDLE.
- Same-edge write commit and read capture to the same word: read returns pre-write data.
## Timing
- Reset (async, while rst=1): all readies 0, bvalid=rvalid=rlast=0, bresp=rresp=0, rdata=0, IDs 0, memory cleared to 0, latches cleared, FSMs idle. First cycle after release: awready=wready=arready=1.
- Write: bvalid rises 1 cycle after the later of the AW/W handshakes. Read: rvalid rises 1 cycle after the AR handshake. Back-to-back handshakes give a throughput of 1 transaction per 2 cycles per path.
- Reset asserted mid-transaction aborts it; the pending response is never issued.
## Test plan
- AW 0x8/ID 3 and W 0xDEADBEEF/strb 0xF/ID 3 in the same cycle, bready=1 -> bvalid next cycle, bresp=0, bid=3; then AR 0x8/ID 5 -> rdata=0xDEADBEEF, rresp=0, rid=5, rlast=1.
- W sent 3 cycles before AW -> wready drops after the W handshake; bvalid follows AW by 1 cycle; data is committed.
- Write 0x11223344 then strb 0x2 with 0xAABBCCDD to the same address -> readback 0x1122CC44.
- AW 0x40 (DEPTH=16) -> bresp=2'b10, no memory change; AR 0x40 -> rdata=0, rresp=2'b10.
- Mismatched W ID or wlast=0 -> bresp=2'b10, no write. Hold bready=0 for 5 cycles -> bvalid/bresp/bid stable, awready=0.
- rst pulse while rvalid=1 -> rvalid=0 immediately; memory reads 0 afterwards.

Source files
------------

// File: rtl/axi_slave_responder.sv
// Memory-backed single-beat AXI slave: independent write and read FSMs over a
// DEPTH-word store with byte strobes, range checking and transaction-ID echo.
module axi_slave_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [3:0]              aw_transaction_id,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [3:0]              w_transaction_id,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [3:0]              b_transaction_id,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [3:0]              ar_transaction_id,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [3:0]              r_transaction_id
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(DEPTH * NBYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  w_state_t              r_wstate;
  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [3:0]            r_awid;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NBYTES-1:0]     r_wstrb;
  logic                  r_wlast;
  logic [3:0]            r_wid;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [3:0]            r_bid;

  r_state_t              r_rstate;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [1:0]            r_rresp;
  logic [3:0]            r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_aw_fire;
  logic                  w_w_fire;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_awaddr_eff;
  logic [3:0]            w_awid_eff;
  logic [DATA_WIDTH-1:0] w_wdata_eff;
  logic [NBYTES-1:0]     w_wstrb_eff;
  logic                  w_wlast_eff;
  logic [3:0]            w_wid_eff;
  logic                  w_wr_ok;
  logic [IDX_W-1:0]      w_wr_idx;
  logic                  w_ar_fire;
  logic                  w_rd_ok;
  logic [IDX_W-1:0]      w_rd_idx;

  // Readies are forced low while reset is asserted
  assign awready = ~rst & (r_wstate == W_IDLE) & ~r_aw_held;
  assign wready  = ~rst & (r_wstate == W_IDLE) & ~r_w_held;
  assign arready = ~rst & (r_rstate == R_IDLE);

  assign w_aw_fire = awvalid & awready;
  assign w_w_fire  = wvalid & wready;
  assign w_commit  = (r_aw_held | w_aw_fire) & (r_w_held | w_w_fire);

  assign w_awaddr_eff = r_aw_held ? r_awaddr : awaddr;
  assign w_awid_eff   = r_aw_held ? r_awid   : aw_transaction_id;
  assign w_wdata_eff  = r_w_held  ? r_wdata  : wdata;
  assign w_wstrb_eff  = r_w_held  ? r_wstrb  : wstrb;
  assign w_wlast_eff  = r_w_held  ? r_wlast  : wlast;
  assign w_wid_eff    = r_w_held  ? r_wid    : w_transaction_id;

  assign w_wr_ok  = (w_awaddr_eff < ADDR_LIMIT) & w_wlast_eff & (w_wid_eff == w_awid_eff);
  assign w_wr_idx = w_awaddr_eff[OFF_W +: IDX_W];

  assign w_ar_fire = arvalid & arready;
  assign w_rd_ok   = araddr < ADDR_LIMIT;
  assign w_rd_idx  = araddr[OFF_W +: IDX_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_wlast   <= 1'b0;
      r_wid     <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            if (w_wr_ok) begin
              for (int b = 0; b < NBYTES; b++)
                if (w_wstrb_eff[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wdata_eff[8*b +: 8];
            end
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            r_bid     <= w_awid_eff;
            r_bvalid  <= 1'b1;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_wstate  <= W_RESP;
          end else begin
            if (w_aw_fire) begin
              r_aw_held <= 1'b1;
              r_awaddr  <= awaddr;
              r_awid    <= aw_transaction_id;
            end
            if (w_w_fire) begin
              r_w_held <= 1'b1;
              r_wdata  <= wdata;
              r_wstrb  <= wstrb;
              r_wlast  <= wlast;
              r_wid    <= w_transaction_id;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Nonblocking memory update means a same-edge read sees pre-write data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rid    <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_fire) begin
            r_rdata  <= w_rd_ok ? r_mem[w_rd_idx] : '0;
            r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rid    <= ar_transaction_id;
            r_rvalid <= 1'b1;
            r_rlast  <= 1'b1;
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign bvalid           = r_bvalid;
  assign bresp            = r_bresp;
  assign b_transaction_id = r_bid;
  assign rvalid           = r_rvalid;
  assign rlast            = r_rlast;
  assign rresp            = r_rresp;
  assign r_transaction_id = r_rid;
  assign rdata            = r_rdata;

endmodule

// File: tb/tb_axi_slave_responder.sv
// Directed bench for axi_slave_responder: a word-array model with response
// queues checked every cycle, plus literal expectations for key vectors.
module tb_axi_slave_responder;

  logic        clk, rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  aw_transaction_id, w_transaction_id, b_transaction_id;
  logic [3:0]  ar_transaction_id, r_transaction_id;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  axi_slave_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .aw_transaction_id(aw_transaction_id),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .w_transaction_id(w_transaction_id),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .b_transaction_id(b_transaction_id),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .ar_transaction_id(ar_transaction_id),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .r_transaction_id(r_transaction_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_mem [16];
  logic [5:0]  bq [$];   // {bresp, bid}
  logic [37:0] rq [$];   // {rdata, rresp, rid}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_write(logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                      logic [3:0] awid, logic [3:0] wid, logic wl);
    logic [1:0] resp;
    if (a < 64 && wl && wid == awid) begin
      resp = 2'b00;
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a / 4][8*b +: 8] = d[8*b +: 8];
    end else begin
      resp = 2'b10;
    end
    bq.push_back({resp, awid});
  endfunction

  function automatic void model_read(logic [31:0] a, logic [3:0] id);
    if (a < 64) rq.push_back({exp_mem[a / 4], 2'b00, id});
    else        rq.push_back({32'h0, 2'b10, id});
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    bq.delete();
    rq.delete();
  endfunction

  // Every cycle a response is presented it must match the head of its queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bvalid) begin
        if (bq.size() == 0) check("b_unexpected", 1, 0);
        else check("b_resp_id", {bresp, b_transaction_id}, bq[0]);
      end
      if (rvalid) begin
        if (rq.size() == 0) check("r_unexpected", 1, 0);
        else begin
          check("r_data_resp_id", {rdata, rresp, r_transaction_id}, rq[0]);
          check("r_last", rlast, 1);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (bvalid && bready && bq.size() > 0) void'(bq.pop_front());
      if (rvalid && rready && rq.size() > 0) void'(rq.pop_front());
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [3:0] awid, input logic [3:0] wid, input logic wl,
                          output logic [1:0] got_resp, output logic [3:0] got_id);
    int n;
    model_write(a, d, s, awid, wid, wl);
    awaddr = a; aw_transaction_id = awid; awvalid = 1'b1;
    wdata = d; wstrb = s; wlast = wl; w_transaction_id = wid; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("aw_w_ready_wait", awready && wready, 1);
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_latency", bvalid, 1);
    got_resp = bresp;
    got_id   = b_transaction_id;
    if (bready) wait_cycle();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] id,
                         output logic [31:0] got_d, output logic [1:0] got_resp,
                         output logic [3:0] got_id);
    int n;
    model_read(a, id);
    araddr = a; ar_transaction_id = id; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ar_ready_wait", arready, 1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    check("rvalid_latency", rvalid, 1);
    got_d = rdata; got_resp = rresp; got_id = r_transaction_id;
    if (rready) wait_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] gd;
  logic [1:0]  gr;
  logic [3:0]  gi;

  initial begin
    model_reset();
    rst = 1'b1;
    awaddr = '0; awvalid = 0; aw_transaction_id = '0;
    wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; w_transaction_id = '0;
    bready = 1; araddr = '0; arvalid = 0; ar_transaction_id = '0; rready = 1;
    repeat (3) wait_cycle();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_valids", {bvalid, rvalid, rlast}, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_readies", {awready, wready, arready}, 3'b111);
    wait_cycle();

    // basic write then read-back
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 4'd3, 4'd3, 1'b1, gr, gi);
    check("w1_bresp", gr, 2'b00);
    check("w1_bid", gi, 4'd3);
    check("w1_bvalid_drop", bvalid, 0);
    do_read(32'h8, 4'd5, gd, gr, gi);
    check("r1_data", gd, 32'hDEADBEEF);
    check("r1_resp_id", {gr, gi}, {2'b00, 4'd5});

    // W three cycles ahead of AW
    model_write(32'hC, 32'hCAFEF00D, 4'hF, 4'd7, 4'd7, 1'b1);
    wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1; w_transaction_id = 4'd7; wvalid = 1;
    @(negedge clk);
    check("wfirst_wready", wready, 1);
    wait_cycle();
    wvalid = 0;
    check("wfirst_wready_drop", wready, 0);
    check("wfirst_awready", awready, 1);
    wait_cycle();
    check("wfirst_no_bvalid1", bvalid, 0);
    wait_cycle();
    check("wfirst_no_bvalid2", bvalid, 0);
    awaddr = 32'hC; aw_transaction_id = 4'd7; awvalid = 1;
    wait_cycle();
    awvalid = 0;
    check("wfirst_bvalid", bvalid, 1);
    wait_cycle();
    do_read(32'hC, 4'd1, gd, gr, gi);
    check("wfirst_data", gd, 32'hCAFEF00D);

    // byte-strobe merge
    do_write(32'h10, 32'h11223344, 4'hF, 4'd2, 4'd2, 1'b1, gr, gi);
    do_write(32'h10, 32'hAABBCCDD, 4'h2, 4'd2, 4'd2, 1'b1, gr, gi);
    do_read(32'h10, 4'd6, gd, gr, gi);
    check("strb_merge", gd, 32'h1122CC44);

    // out of range
    do_write(32'h40, 32'h55555555, 4'hF, 4'd4, 4'd4, 1'b1, gr, gi);
    check("oor_bresp", gr, 2'b10);
    do_read(32'h40, 4'd9, gd, gr, gi);
    check("oor_rdata", gd, 0);
    check("oor_rresp", gr, 2'b10);
    do_read(32'h0, 4'd9, gd, gr, gi);
    check("oor_no_alias", gd, 0);

    // protocol errors
    do_write(32'h4, 32'h12345678, 4'hF, 4'd1, 4'd2, 1'b1, gr, gi);
    check("idmis_bresp", gr, 2'b10);
    do_write(32'h4, 32'h12345678, 4'hF, 4'd1, 4'd1, 1'b0, gr, gi);
    check("nolast_bresp", gr, 2'b10);
    do_read(32'h4, 4'd0, gd, gr, gi);
    check("err_no_write", gd, 0);

    // backpressure on B
    bready = 0;
    do_write(32'h14, 32'h01020304, 4'hF, 4'hA, 4'hA, 1'b1, gr, gi);
    for (int i = 0; i < 5; i++) begin
      wait_cycle();
      check("hold_bvalid", {bvalid, bresp, b_transaction_id}, {1'b1, 2'b00, 4'hA});
      check("hold_awready", awready, 0);
    end
    bready = 1;
    wait_cycle();
    check("hold_release", bvalid, 0);
    do_read(32'h17, 4'd3, gd, gr, gi);
    check("low_bits_ignored", gd, 32'h01020304);

    // reset while a read response is pending
    rready = 0;
    do_read(32'h8, 4'd4, gd, gr, gi);
    wait_cycle();
    check("pending_rvalid", rvalid, 1);
    rst = 1;
    #1;
    check("mid_rst_rvalid", {rvalid, rlast}, 0);
    check("mid_rst_arready", arready, 0);
    model_reset();
    wait_cycle();
    rst = 0;
    rready = 1;
    @(negedge clk);
    check("mid_rst_readies", {awready, wready, arready}, 3'b111);
    wait_cycle();
    do_read(32'h8, 4'd2, gd, gr, gi);
    check("mem_cleared", gd, 0);
    do_read(32'h10, 4'd2, gd, gr, gi);
    check("mem_cleared2", gd, 0);

    repeat (2) wait_cycle();
    check("b_queue_drained", bq.size(), 0);
    check("r_queue_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
